axim_stream_responder: RTL and testbench

// - Memory-backed responder for the vector core's MCU<=>AXIM control/stream interface (both channels).
// - Read channel: accepts rstart plus offset/size, streams words out of a local RAM, then pulses rdone.
// - Write channel: accepts wstart plus offset/size, sinks strobed words into the same RAM, then pulses wdone.
// - Stands in for the AXI master + DDR in standalone vector-core sims and FPGA bring-up without a PS.

---
 rtl/axim_resp_pkg.sv | 39 +++
 rtl/stream_skid_buf.sv | 73 +++++++
 rtl/axim_stream_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_axim_stream_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axim_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axim_resp_pkg
// Purpose : Shared types and helpers for the AXIM stream responder.
//           - rd_state_t / wr_state_t : channel FSM encodings
//           - LFSR_SEED               : stall-injection LFSR reset value
//           - beats_f()               : bytes-to-beats conversion (ceil)
// Revision: 1.0 - initial release
// ============================================================================
package axim_resp_pkg;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_STREAM = 2'd1,
        R_DONE   = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DONE = 2'd2
    } wr_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Number of beats needed to move 'size' bytes when each beat carries
    // 'bytes' bytes; a partial trailing word still costs a full beat.
    function automatic logic [63:0] beats_f(input logic [63:0] size,
                                            input logic [63:0] bytes);
        logic [63:0] q;
        q = size / bytes;
        if ((size % bytes) != 64'd0) begin
            q = q + 64'd1;
        end
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : stream_skid_buf
// Purpose : Two-entry FIFO holding prefetched read words (data + last flag)
//           so the RAM read pipeline can run ahead of downstream ready.
// Ports   : clk, reset        - clock / synchronous active-high reset
//           push, push_data   - new entry from the RAM read register
//           pop               - head entry consumed this cycle
//           head_data         - oldest entry (registered)
//           head_valid        - buffer non-empty
//           count             - current occupancy (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module stream_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic [1:0]       r_count;
    logic             w_pop;

    // A pop on an empty buffer is meaningless; never let it underflow.
    assign w_pop = pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry0 <= push_data;
                    end else begin
                        r_entry1 <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind the survivor.
                    if (r_count == 2'd1) begin
                        r_entry0 <= push_data;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = r_entry0;
    assign head_valid = (r_count != 2'd0);
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/axim_stream_responder.sv
`default_nettype none
// ============================================================================
// Module  : axim_stream_responder
// Purpose : Memory-backed stand-in for the AXI master + DDR behind the vector
//           core's MCU<=>AXIM control/stream interface.
//           Read  : rstart + offset/size -> stream words out of RAM -> rdone
//           Write : wstart + offset/size -> sink strobed words into RAM -> wdone
//           Backdoor port for preload / inspection.
// Ports   : clk, reset (sync, active-high)
//           ctrl_r* / rd_t*  - read control and read stream
//           ctrl_w* / wr_t*  - write control and write stream (+ byte mask)
//           bd_*             - backdoor write and combinational read
// Config  : `AXIM_RESP_STALL_INJ_EN - LFSR-driven stall injection on both
//           streams (rd_tvalid_o / wr_tready_o dropped when LFSR[1:0]==0)
// Revision: 1.0 - initial release
// ============================================================================
module axim_stream_responder
    import axim_resp_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int MEM_DEPTH          = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_raddr_offset_i,
    input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_rxfer_size_i,
    input  logic                              ctrl_rstart_i,
    output logic                              ctrl_rdone_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_tdata_o,
    output logic                              rd_tvalid_o,
    input  logic                              rd_tready_i,
    output logic                              rd_tlast_o,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_waddr_offset_i,
    input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_wxfer_size_i,
    input  logic                              ctrl_wstart_i,
    output logic                              ctrl_wdone_o,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_tdata_i,
    input  logic                              wr_tvalid_i,
    output logic                              wr_tready_o,
    input  logic                              ctrl_wstrb_msk_en_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_tstrb_msk_i,
    input  logic                              bd_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]      bd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     bd_wdata_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     bd_rdata_o
);

    localparam int B   = C_M_AXI_DATA_WIDTH / 8;
    localparam int LGB = $clog2(B);
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int XW  = C_XFER_SIZE_WIDTH;

    // ------------------------------------------------------------------
    // Stall injection
    // ------------------------------------------------------------------
    logic w_stall;
`ifdef AXIM_RESP_STALL_INJ_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    rd_state_t        r_rd_state;
    logic [AW-1:0]    r_rd_addr;
    logic [XW-1:0]    r_rd_beats;
    logic [XW-1:0]    r_rd_issued;
    logic             r_ram_pend;
    logic             r_ram_last;
    logic [DW-1:0]    r_ram_q;
    logic [XW-1:0]    w_rbeats;
    logic             w_rd_issue;
    logic             w_rd_pop;
    logic [2:0]       w_occ;
    logic [DW:0]      w_head;
    logic             w_head_valid;
    logic [1:0]       w_buf_count;

    wr_state_t        r_wr_state;
    logic [AW-1:0]    r_wr_addr;
    logic [XW-1:0]    r_wr_beats;
    logic [XW-1:0]    r_wr_cnt;
    logic             r_wr_msk_en;
    logic [XW-1:0]    w_wbeats;
    logic             w_wr_hs;

    logic [DW-1:0]    r_mem [MEM_DEPTH];
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;
    logic [DW-1:0]    w_mem_wdata;
    logic [B-1:0]     w_mem_be;

    assign w_rbeats = XW'(beats_f(64'(ctrl_rxfer_size_i), 64'(B)));
    assign w_wbeats = XW'(beats_f(64'(ctrl_wxfer_size_i), 64'(B)));

    // ------------------------------------------------------------------
    // RAM: one shared write port, one sync read port, one async backdoor read
    // ------------------------------------------------------------------
    // The stream write owns the write port; a colliding backdoor write is lost.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = bd_addr_i;
        w_mem_wdata = bd_wdata_i;
        w_mem_be    = '1;
        if (w_wr_hs && !reset) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_wr_addr;
            w_mem_wdata = wr_tdata_i;
            w_mem_be    = r_wr_msk_en ? wr_tstrb_msk_i : '1;
        end else if (bd_we_i) begin
            w_mem_we = 1'b1;
        end
    end

    // Read and write share one block so a same-address collision reads old data.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < B; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_waddr][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
                end
            end
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_rd_addr];
        end
    end

    assign bd_rdata_o = r_mem[bd_addr_i];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    // Words in flight (RAM register) plus buffered words must never exceed
    // the two buffer slots, counting a slot freed by this cycle's pop.
    assign w_occ      = {1'b0, w_buf_count} + {2'b00, r_ram_pend};
    assign w_rd_pop   = rd_tvalid_o && rd_tready_i;
    assign w_rd_issue = (r_rd_state == R_STREAM) && (r_rd_issued != r_rd_beats) &&
                        ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_rd_pop));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state  <= R_IDLE;
            r_rd_addr   <= '0;
            r_rd_beats  <= '0;
            r_rd_issued <= '0;
            r_ram_pend  <= 1'b0;
            r_ram_last  <= 1'b0;
        end else begin
            r_ram_pend <= w_rd_issue;
            if (w_rd_issue) begin
                r_ram_last  <= (r_rd_issued == r_rd_beats - XW'(1));
                r_rd_addr   <= r_rd_addr + AW'(1);
                r_rd_issued <= r_rd_issued + XW'(1);
            end
            case (r_rd_state)
                R_IDLE: begin
                    if (ctrl_rstart_i) begin
                        r_rd_addr   <= AW'(ctrl_raddr_offset_i >> LGB);
                        r_rd_beats  <= w_rbeats;
                        r_rd_issued <= '0;
                        r_rd_state  <= (w_rbeats == '0) ? R_DONE : R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (w_rd_pop && w_head[DW]) begin
                        r_rd_state <= R_DONE;
                    end
                end
                R_DONE:  r_rd_state <= R_IDLE;
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH (DW + 1)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (r_ram_pend),
        .push_data  ({r_ram_last, r_ram_q}),
        .pop        (w_rd_pop),
        .head_data  (w_head),
        .head_valid (w_head_valid),
        .count      (w_buf_count)
    );

    assign rd_tvalid_o  = w_head_valid && !w_stall;
    assign rd_tdata_o   = w_head[DW-1:0];
    assign rd_tlast_o   = w_head[DW] && rd_tvalid_o;
    assign ctrl_rdone_o = (r_rd_state == R_DONE);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    assign wr_tready_o  = (r_wr_state == W_RECV) && !w_stall;
    assign w_wr_hs      = wr_tvalid_i && wr_tready_o;
    assign ctrl_wdone_o = (r_wr_state == W_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state  <= W_IDLE;
            r_wr_addr   <= '0;
            r_wr_beats  <= '0;
            r_wr_cnt    <= '0;
            r_wr_msk_en <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (ctrl_wstart_i) begin
                        r_wr_addr   <= AW'(ctrl_waddr_offset_i >> LGB);
                        r_wr_beats  <= w_wbeats;
                        r_wr_cnt    <= '0;
                        r_wr_msk_en <= ctrl_wstrb_msk_en_i;
                        r_wr_state  <= (w_wbeats == '0) ? W_DONE : W_RECV;
                    end
                end
                W_RECV: begin
                    if (w_wr_hs) begin
                        r_wr_addr <= r_wr_addr + AW'(1);
                        r_wr_cnt  <= r_wr_cnt + XW'(1);
                        if (r_wr_cnt == r_wr_beats - XW'(1)) begin
                            r_wr_state <= W_DONE;
                        end
                    end
                end
                W_DONE:  r_wr_state <= W_IDLE;
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axim_stream_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_axim_stream_responder
// Purpose : Self-checking bench for axim_stream_responder. A plain array holds
//           the expected memory image; reads are compared beat by beat against
//           it and writes update it from byte-mask rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axim_stream_responder;

    localparam int DEPTH = 64;
    localparam int B     = 4;
    localparam int AWD   = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       raddr, rsize, waddr, wsize;
    logic              rstart, rdone, rvalid, rready, rlast;
    logic [31:0]       rdata;
    logic              wstart, wdone, wvalid, wready, wmsk_en;
    logic [31:0]       wdata;
    logic [3:0]        wmsk;
    logic              bd_we;
    logic [AWD-1:0]    bd_addr;
    logic [31:0]       bd_wdata, bd_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wq_data [64];
    logic [3:0]  wq_mask [64];

    always #5 clk = ~clk;

    axim_stream_responder #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_XFER_SIZE_WIDTH  (32),
        .MEM_DEPTH          (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ctrl_raddr_offset_i (raddr),
        .ctrl_rxfer_size_i   (rsize),
        .ctrl_rstart_i       (rstart),
        .ctrl_rdone_o        (rdone),
        .rd_tdata_o          (rdata),
        .rd_tvalid_o         (rvalid),
        .rd_tready_i         (rready),
        .rd_tlast_o          (rlast),
        .ctrl_waddr_offset_i (waddr),
        .ctrl_wxfer_size_i   (wsize),
        .ctrl_wstart_i       (wstart),
        .ctrl_wdone_o        (wdone),
        .wr_tdata_i          (wdata),
        .wr_tvalid_i         (wvalid),
        .wr_tready_o         (wready),
        .ctrl_wstrb_msk_en_i (wmsk_en),
        .wr_tstrb_msk_i      (wmsk),
        .bd_we_i             (bd_we),
        .bd_addr_i           (bd_addr),
        .bd_wdata_i          (bd_wdata),
        .bd_rdata_o          (bd_rdata)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int addr, input logic [31:0] data);
        bd_we    = 1'b1;
        bd_addr  = AWD'(addr);
        bd_wdata = data;
        tick();
        bd_we    = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic bd_check(input int addr, input string tag);
        bd_addr = AWD'(addr);
        #1;
        check_val(tag, 64'(bd_rdata), 64'(ref_mem[addr]));
    endtask

    // mode: 0 = ready always high, 1 = ready toggles 1,0,1,0, 2 = random ready
    task automatic do_read(input int offset, input int size, input int mode, input bit busy_start);
        int beats, base, hs, cyc, first_v, last_hs;
        bit got_done, prev_stall, tog;
        logic [31:0] prev_d;
        beats = (size + B - 1) / B;
        base  = offset / B;
        hs = 0; cyc = 0; first_v = -1; last_hs = -1;
        got_done = 0; prev_stall = 0; tog = 1; prev_d = '0;
        raddr = 32'(offset); rsize = 32'(size); rstart = 1'b1;
        tick();
        rstart = 1'b0;
        raddr  = $urandom;  // later offset/size changes must be ignored
        rsize  = $urandom_range(1, 200);
        while (cyc < 400) begin
            if (rdone) begin
                got_done = 1;
                break;
            end
            if (prev_stall) begin
                check_val("rd_stall_valid", 64'(rvalid), 64'd1);
                check_val("rd_stall_data", 64'(rdata), 64'(prev_d));
            end
            if (rvalid && first_v < 0) first_v = cyc;
            case (mode)
                0:       rready = 1'b1;
                1:       rready = tog;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            if (busy_start && cyc == 3) begin
                rstart = 1'b1;
                raddr  = 32'(offset + 8 * B);
                rsize  = 32'd64;
            end
            if (rvalid && rready) begin
                if (hs < beats) begin
                    check_val("rd_data", 64'(rdata), 64'(ref_mem[(base + hs) % DEPTH]));
                    check_val("rd_last", 64'(rlast), 64'(hs == beats - 1));
                end
                hs++;
                last_hs = cyc;
            end
            prev_stall = rvalid && !rready;
            prev_d     = rdata;
            tick();
            rstart = 1'b0;
            cyc++;
        end
        check_val("rd_done_seen", 64'(got_done), 64'd1);
        check_val("rd_beat_count", 64'(hs), 64'(beats));
        if (beats == 0) check_val("rd_done_cycle", 64'(cyc), 64'd0);
        else            check_val("rd_done_cycle", 64'(cyc), 64'(last_hs + 1));
`ifndef AXIM_RESP_STALL_INJ_EN
        if (beats > 0) check_val("rd_first_latency", 64'(first_v), 64'd2);
        if (beats > 0 && mode == 0) check_val("rd_full_rate", 64'(last_hs - first_v), 64'(beats - 1));
`endif
        tick();
        check_val("rd_done_pulse", 64'(rdone), 64'd0);
        check_val("rd_idle_valid", 64'(rvalid), 64'd0);
        if (busy_start) begin
            tick();
            check_val("rd_no_queued_start", 64'(rvalid), 64'd0);
        end
    endtask

    // Uses wq_data/wq_mask; vmode 0 = valid always high, 1 = random valid
    task automatic do_write(input int offset, input int size, input bit mask_en, input int vmode);
        int beats, base, i, cyc, last_hs, a;
        bit got_done;
        beats = (size + B - 1) / B;
        base  = offset / B;
        i = 0; cyc = 0; last_hs = -1; got_done = 0;
        waddr = 32'(offset); wsize = 32'(size); wmsk_en = mask_en; wstart = 1'b1;
        tick();
        wstart  = 1'b0;
        waddr   = $urandom;
        wsize   = $urandom_range(1, 200);
        wmsk_en = ~mask_en;
        while (cyc < 400) begin
            if (wdone) begin
                got_done = 1;
                break;
            end
            wvalid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wdata  = (i < beats) ? wq_data[i] : 32'hDEAD_BEEF;
            wmsk   = (i < beats) ? wq_mask[i] : 4'hF;
            if (wvalid && wready) begin
                if (i < beats) begin
                    a = (base + i) % DEPTH;
                    for (int b = 0; b < B; b++) begin
                        if (!mask_en || wq_mask[i][b]) ref_mem[a][b*8 +: 8] = wq_data[i][b*8 +: 8];
                    end
                end
                i++;
                last_hs = cyc;
            end
            tick();
            cyc++;
        end
        check_val("wr_done_seen", 64'(got_done), 64'd1);
        check_val("wr_beat_count", 64'(i), 64'(beats));
        if (beats == 0) check_val("wr_done_cycle", 64'(cyc), 64'd0);
        else            check_val("wr_done_cycle", 64'(cyc), 64'(last_hs + 1));
        check_val("wr_ready_in_done", 64'(wready), 64'd0);
        tick();
        wvalid = 1'b0;
        check_val("wr_done_pulse", 64'(wdone), 64'd0);
        check_val("wr_idle_ready", 64'(wready), 64'd0);
    endtask

    initial begin
        int hs, cyc, nd, off, sz;
        logic [31:0] old5, new5;
        bit seen;

        reset = 1'b1; rstart = 0; wstart = 0; rready = 0; wvalid = 0; wmsk_en = 0;
        raddr = 0; rsize = 0; waddr = 0; wsize = 0; wdata = 0; wmsk = 0;
        bd_we = 0; bd_addr = 0; bd_wdata = 0;
        tick();
        tick();
        check_val("rst_rvalid", 64'(rvalid), 64'd0);
        check_val("rst_rlast", 64'(rlast), 64'd0);
        check_val("rst_rdone", 64'(rdone), 64'd0);
        check_val("rst_rdata", 64'(rdata), 64'd0);
        check_val("rst_wready", 64'(wready), 64'd0);
        check_val("rst_wdone", 64'(wdone), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) bd_write(i, (i < 8) ? 32'h100 + 32'(i) : $urandom);

        // Full-rate read of 0x100..0x107, then the same with toggling ready
        do_read(0, 32, 0, 0);
        do_read(0, 32, 1, 0);

        // Masked write at word 4..6
        for (int i = 0; i < 3; i++) wq_data[i] = 32'hAABBCCDD;
        wq_mask[0] = 4'hF; wq_mask[1] = 4'h3; wq_mask[2] = 4'h8;
        do_write(16, 12, 1'b1, 0);
        bd_check(4, "wr_mask_word4");
        bd_check(5, "wr_mask_word5");
        bd_check(6, "wr_mask_word6");
        bd_addr = AWD'(5); #1;
        check_val("wr_mask_word5_const", 64'(bd_rdata), 64'h0000_CCDD);
        bd_addr = AWD'(6); #1;
        check_val("wr_mask_word6_const", 64'(bd_rdata), 64'hAA00_0106);
        bd_check(7, "wr_no_extra_beat");

        // Address wrap and zero-size transfers
        do_read((DEPTH - 2) * B, 4 * B, 0, 0);
        do_read(0, 0, 0, 0);
        do_write(8, 0, 1'b0, 0);

        // Reset in the middle of a read at beat 3
        raddr = 0; rsize = 32; rready = 1'b1; rstart = 1'b1;
        tick();
        rstart = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 50) begin
            if (rvalid && rready) hs++;
            tick();
            cyc++;
        end
        check_val("rst_mid_reach_beat3", 64'(hs), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_mid_valid", 64'(rvalid), 64'd0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdone) nd++;
            tick();
        end
        check_val("rst_mid_no_done", 64'(nd), 64'd0);
        do_read(8, 20, 2, 1);

        // Same-cycle stream write and read of word 5: read returns old data
        old5 = ref_mem[5];
        new5 = old5 ^ 32'h5A5A_F00F;
        raddr = 20; rsize = 4; rstart = 1'b1;
        waddr = 20; wsize = 4; wstart = 1'b1; wmsk_en = 1'b0;
        wvalid = 1'b1; wdata = new5; wmsk = 4'h0; rready = 1'b1;
        tick();
        rstart = 1'b0; wstart = 1'b0;
        check_val("coll_wready", 64'(wready), 64'd1);
        tick();
        wvalid = 1'b0;
        ref_mem[5] = new5;
        check_val("coll_wdone", 64'(wdone), 64'd1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rvalid) begin
                seen = 1;
                check_val("coll_read_old", 64'(rdata), 64'(old5));
            end
            tick();
        end
        check_val("coll_read_seen", 64'(seen), 64'd1);
        check_val("coll_rdone", 64'(rdone), 64'd1);
        tick();
        bd_check(5, "coll_new_value");

        // Randomized write/read mix against the reference image
        for (int t = 0; t < 25; t++) begin
            off = $urandom_range(0, DEPTH * B - 1);
            sz  = $urandom_range(0, 48);
            for (int i = 0; i < 64; i++) begin
                wq_data[i] = $urandom;
                wq_mask[i] = 4'($urandom_range(0, 15));
            end
            do_write(off, sz, 1'($urandom_range(0, 1)), 1);
            do_read(off, sz, 2, 0);
            do_read($urandom_range(0, DEPTH * B - 1), $urandom_range(0, 60), 2, 0);
        end
        for (int i = 0; i < DEPTH; i += 7) bd_check(i, "final_image");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
